// File: rtl/systolic_conv1d_engine_if.sv
// Sample-in / result-out stream pair of the 1-D convolution engine.
// The engine binds to the slave modport; the feeding/consuming side uses master.
interface systolic_conv1d_engine_if #(
  parameter int WIDTH = 8
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [WIDTH-1:0] m_data;

  modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/systolic_conv1d_engine.sv
// Framed CELL_COUNT-tap signed valid-mode 1-D convolution with banked runtime weights,
// two-stage back-pressured pipeline (products, then sum/shift/saturate).
module systolic_conv1d_engine #(
  parameter  int WIDTH        = 8,
  parameter  int ACC_WIDTH    = 24,
  parameter  int CELL_COUNT   = 3,
  parameter  int KERNEL_COUNT = 4,
  parameter  int LEN_WIDTH    = 16,
  parameter  int SHIFT        = 0,
  localparam int BANK_W       = (KERNEL_COUNT > 1) ? $clog2(KERNEL_COUNT) : 1,
  localparam int CELL_W       = (CELL_COUNT > 1) ? $clog2(CELL_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ce,
  input  logic                    i_w_we,
  input  logic [BANK_W-1:0]       i_w_bank,
  input  logic [CELL_W-1:0]       i_w_cell,
  input  logic signed [WIDTH-1:0] i_w_data,
  input  logic                    i_start,
  input  logic [BANK_W-1:0]       i_start_bank,
  input  logic [LEN_WIDTH-1:0]    i_frame_len,
  systolic_conv1d_engine_if.slave io_strm,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (WIDTH-1)));

  function automatic logic signed [ACC_WIDTH-1:0] shr_floor(input logic signed [ACC_WIDTH-1:0] v);
    return v >>> SHIFT;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [WIDTH-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[WIDTH-1:0];
    else                  r = v[WIDTH-1:0];
    return r;
  endfunction

  state_t                        r_state, w_state_nxt;
  logic signed [WIDTH-1:0]       r_w [KERNEL_COUNT][CELL_COUNT];
  logic signed [WIDTH-1:0]       r_x [CELL_COUNT-1];
  logic [CELL_W-1:0]             r_fill;
  logic [BANK_W-1:0]             r_bank;
  logic [LEN_WIDTH-1:0]          r_left;
  logic signed [ACC_WIDTH-1:0]   r_prod_p1 [CELL_COUNT];
  logic                          r_vld_p1;
  logic signed [WIDTH-1:0]       r_data_p2;
  logic                          r_vld_p2;

  logic signed [WIDTH-1:0]       w_win  [CELL_COUNT];
  logic signed [ACC_WIDTH-1:0]   w_prod [CELL_COUNT];
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic                          w_stall, w_adv, w_s_ready, w_s_hs, w_primed;

  assign w_stall   = r_vld_p2 & ~io_strm.m_ready;
  assign w_adv     = i_ce & ~w_stall;
  assign w_s_ready = i_ce & (r_state == S_RUN) & (r_left != '0) & ~w_stall;
  assign w_s_hs    = io_strm.s_valid & w_s_ready;
  // A result exists only once CELL_COUNT-1 earlier samples of this frame sit in the delay line.
  assign w_primed  = (r_fill == CELL_W'(CELL_COUNT - 1));

  assign io_strm.s_ready = w_s_ready;
  assign io_strm.m_valid = r_vld_p2;
  assign io_strm.m_data  = r_data_p2;

  always_comb begin
    for (int k = 0; k < CELL_COUNT; k++) w_win[k] = '0;
    for (int k = 0; k < CELL_COUNT - 1; k++) w_win[k] = r_x[k];
    w_win[CELL_COUNT-1] = io_strm.s_data;
    for (int k = 0; k < CELL_COUNT; k++)
      w_prod[k] = ACC_WIDTH'(r_w[r_bank][k]) * ACC_WIDTH'(w_win[k]);
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < CELL_COUNT; k++) w_sum = w_sum + r_prod_p1[k];
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (i_start)
                 w_state_nxt = (i_frame_len < LEN_WIDTH'(CELL_COUNT)) ? S_DONE : S_RUN;
      S_RUN:   if (w_s_hs && r_left == LEN_WIDTH'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_vld_p1 && !r_vld_p2) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bank  <= '0;
      r_left  <= '0;
      r_fill  <= '0;
      for (int k = 0; k < CELL_COUNT - 1; k++) r_x[k] <= '0;
      for (int b = 0; b < KERNEL_COUNT; b++)
        for (int k = 0; k < CELL_COUNT; k++) r_w[b][k] <= '0;
    end else if (i_ce) begin
      r_state <= w_state_nxt;
      if (i_w_we && r_state == S_IDLE && int'(i_w_bank) < KERNEL_COUNT && int'(i_w_cell) < CELL_COUNT)
        r_w[i_w_bank][i_w_cell] <= i_w_data;
      if (r_state == S_IDLE && i_start) begin
        r_bank <= i_start_bank;
        r_left <= i_frame_len;
        r_fill <= '0;
        for (int k = 0; k < CELL_COUNT - 1; k++) r_x[k] <= '0;
      end else if (w_s_hs) begin
        r_left <= r_left - LEN_WIDTH'(1);
        if (!w_primed) r_fill <= r_fill + CELL_W'(1);
        for (int k = 0; k < CELL_COUNT - 2; k++) r_x[k] <= r_x[k+1];
        r_x[CELL_COUNT-2] <= io_strm.s_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      for (int k = 0; k < CELL_COUNT; k++) r_prod_p1[k] <= '0;
    end else if (w_adv) begin
      // stage 1: per-tap products captured on a completing sample handshake
      r_vld_p1 <= w_s_hs & w_primed;
      if (w_s_hs && w_primed) r_prod_p1 <= w_prod;
      // stage 2: tap sum, floor shift, saturation
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_data_p2 <= sat(shr_floor(w_sum));
    end
  end

endmodule

// File: tb/tb_systolic_conv1d_engine.sv
// Bench: SHIFT=0 and SHIFT=2 engines driven in lockstep; table vectors, hand sequences, random frames vs model.
module tb_systolic_conv1d_engine;
  localparam int CELL_COUNT = 3;

  logic clk = 1'b0;
  logic rst, ce, w_we, start, s_valid, m_ready;
  logic [1:0] w_bank, w_cell, start_bank;
  logic signed [7:0] w_data, s_data;
  logic [15:0] frame_len;
  logic busy0, done0, busy1, done1;

  systolic_conv1d_engine_if #(.WIDTH(8)) sif0 ();
  systolic_conv1d_engine_if #(.WIDTH(8)) sif1 ();
  assign sif0.s_valid = s_valid;  assign sif1.s_valid = s_valid;
  assign sif0.s_data  = s_data;   assign sif1.s_data  = s_data;
  assign sif0.m_ready = m_ready;  assign sif1.m_ready = m_ready;

  systolic_conv1d_engine #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .i_ce(ce), .i_w_we(w_we), .i_w_bank(w_bank), .i_w_cell(w_cell),
    .i_w_data(w_data), .i_start(start), .i_start_bank(start_bank), .i_frame_len(frame_len),
    .io_strm(sif0), .o_busy(busy0), .o_done(done0));
  systolic_conv1d_engine #(.SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .i_ce(ce), .i_w_we(w_we), .i_w_bank(w_bank), .i_w_cell(w_cell),
    .i_w_data(w_data), .i_start(start), .i_start_bank(start_bank), .i_frame_len(frame_len),
    .io_strm(sif1), .o_busy(busy1), .o_done(done1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       bank;
    logic [0:2][7:0]  w;
    logic [7:0]       len;
    logic [0:7][7:0]  x;
    logic [3:0]       nres;
    logic [0:5][7:0]  e0;
    logic [0:5][7:0]  e2;
    logic             wr_run;
  } vec_t;

  vec_t vt [6];
  int   xbuf [64];
  int   wm [4][3];
  int   exp0_q[$], exp1_q[$], act0_q[$], act1_q[$];
  int   nchecks = 0, nerr = 0;

  task automatic check(input string name, input int act, input int expv);
    nchecks++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int clamp8(input int v);
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Reference: valid convolution over the mirrored weights, then floor shift and clamp.
  function automatic void model(input int bank, input int len);
    int y;
    exp0_q.delete(); exp1_q.delete();
    for (int j = 0; j + CELL_COUNT <= len; j++) begin
      y = 0;
      for (int k = 0; k < CELL_COUNT; k++) y += wm[bank][k] * xbuf[j+k];
      exp0_q.push_back(clamp8(y));
      exp1_q.push_back(clamp8(y >>> 2));
    end
  endfunction

  task automatic write_w(input int bank, input int a, input int b, input int c);
    int wv[3];
    wv[0] = a; wv[1] = b; wv[2] = c;
    for (int k = 0; k < 3; k++) begin
      w_we = 1'b1; w_bank = 2'(bank); w_cell = 2'(k); w_data = 8'(wv[k]);
      @(posedge clk); #1;
      wm[bank][k] = wv[k];
    end
    w_we = 1'b0;
  endtask

  task automatic run_frame(input int bank, input int len, input bit rnd, input int stall_len,
                           input bit wr_run, input bit chk_time);
    int idx, lc, nhs, hs3_lc, first_lc, last_lc, stalled, dcnt0, dcnt1;
    bit hs, fin;
    idx = 0; lc = 0; nhs = 0; hs3_lc = -1; first_lc = -1; last_lc = -1;
    stalled = 0; dcnt0 = 0; dcnt1 = 0; fin = 1'b0;
    act0_q.delete(); act1_q.delete();
    start = 1'b1; start_bank = 2'(bank); frame_len = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin) begin
      s_valid = (idx < len) && (!rnd || $urandom_range(0, 3) != 0);
      s_data  = 8'(xbuf[idx]);
      m_ready = (stall_len > 0 && stalled < stall_len) ? 1'b0 : (!rnd || $urandom_range(0, 3) != 0);
      w_we = wr_run && lc == 1; w_bank = 2'(bank); w_cell = 2'd2; w_data = 8'sd100;
      #1;
      hs = s_valid && sif0.s_ready;
      if (hs) begin
        nhs++;
        if (nhs == CELL_COUNT) hs3_lc = lc;
      end
      if (sif0.m_valid && m_ready) begin
        act0_q.push_back(int'(sif0.m_data));
        if (first_lc < 0) first_lc = lc;
        last_lc = lc;
      end
      if (sif1.m_valid && m_ready) act1_q.push_back(int'(sif1.m_data));
      if (sif0.m_valid && !m_ready) begin
        stalled++;
        check("stall_s_ready", int'(sif0.s_ready), 0);
        if (act0_q.size() < exp0_q.size())
          check("stall_hold_m_data", int'(sif0.m_data), exp0_q[act0_q.size()]);
      end
      if (done0) dcnt0++;
      if (done1) dcnt1++;
      if (!busy0 && !busy1) fin = 1'b1;
      else if (lc > 1000) begin
        check("frame_timeout", lc, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (hs) idx++;
        lc++;
      end
    end
    s_valid = 1'b0; w_we = 1'b0; m_ready = 1'b1;
    check("done_pulses0", dcnt0, 1);
    check("done_pulses1", dcnt1, 1);
    check("n_results0", act0_q.size(), exp0_q.size());
    check("n_results1", act1_q.size(), exp1_q.size());
    for (int i = 0; i < exp0_q.size(); i++)
      check($sformatf("res_shift0[%0d]", i), (i < act0_q.size()) ? act0_q[i] : -999, exp0_q[i]);
    for (int i = 0; i < exp1_q.size(); i++)
      check($sformatf("res_shift2[%0d]", i), (i < act1_q.size()) ? act1_q[i] : -999, exp1_q[i]);
    if (stall_len > 0) check("stall_cycles", stalled, stall_len);
    if (chk_time) begin
      check("first_result_latency", first_lc - hs3_lc, 2);
      check("back_to_back_results", last_lc - first_lc, exp0_q.size() - 1);
    end
  endtask

  task automatic load_t1();
    xbuf[0] = 0; xbuf[1] = 1; xbuf[2] = 0; xbuf[3] = 2; xbuf[4] = 5;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int b, len, nmv, ndn;
    rst = 1'b1; ce = 1'b1; w_we = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    w_bank = '0; w_cell = '0; w_data = '0; start_bank = '0; frame_len = '0; s_data = '0;
    for (int i = 0; i < 64; i++) xbuf[i] = 0;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 3; k++) wm[i][k] = 0;

    vt[0] = '{bank: 2'd0, w: {8'd1, 8'd2, 8'd3}, len: 8'd5, x: {8'd0, 8'd1, 8'd0, 8'd2, 8'd5, 8'd0, 8'd0, 8'd0},
              nres: 4'd3, e0: {8'd2, 8'd7, 8'd19, 24'd0}, e2: {8'd0, 8'd1, 8'd4, 24'd0}, wr_run: 1'b0};
    vt[1] = '{bank: 2'd0, w: {8'd127, 8'd127, 8'd127}, len: 8'd3, x: {8'd127, 8'd127, 8'd127, 40'd0},
              nres: 4'd1, e0: {8'd127, 40'd0}, e2: {8'd127, 40'd0}, wr_run: 1'b0};
    vt[2] = '{bank: 2'd0, w: {8'd127, 8'd127, 8'd127}, len: 8'd3, x: {8'h80, 8'h80, 8'h80, 40'd0},
              nres: 4'd1, e0: {8'h80, 40'd0}, e2: {8'h80, 40'd0}, wr_run: 1'b0};
    vt[3] = '{bank: 2'd0, w: {8'hFF, 8'hFE, 8'hFD}, len: 8'd3, x: {8'd0, 8'd1, 8'd0, 40'd0},
              nres: 4'd1, e0: {8'hFE, 40'd0}, e2: {8'hFF, 40'd0}, wr_run: 1'b0};
    vt[4] = '{bank: 2'd1, w: {8'd0, 8'd0, 8'd1}, len: 8'd6, x: {8'd3, 8'hFC, 8'd5, 8'hFA, 8'd7, 8'hF8, 16'd0},
              nres: 4'd4, e0: {8'd5, 8'hFA, 8'd7, 8'hF8, 16'd0}, e2: {8'd1, 8'hFE, 8'd1, 8'hFE, 16'd0}, wr_run: 1'b1};
    vt[5] = '{bank: 2'd2, w: {8'd1, 8'd1, 8'd1}, len: 8'd2, x: {8'd9, 8'd9, 48'd0},
              nres: 4'd0, e0: 48'd0, e2: 48'd0, wr_run: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", int'(sif0.s_ready), 0);
    check("rst_m_valid", int'(sif0.m_valid), 0);
    check("rst_m_data", int'(sif0.m_data), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      write_w(int'(vt[i].bank), int'($signed(vt[i].w[0])), int'($signed(vt[i].w[1])), int'($signed(vt[i].w[2])));
      for (int k = 0; k < 8; k++) xbuf[k] = int'($signed(vt[i].x[k]));
      exp0_q.delete(); exp1_q.delete();
      for (int k = 0; k < int'(vt[i].nres); k++) begin
        exp0_q.push_back(int'($signed(vt[i].e0[k])));
        exp1_q.push_back(int'($signed(vt[i].e2[k])));
      end
      run_frame(int'(vt[i].bank), int'(vt[i].len), 1'b0, 0, vt[i].wr_run, i == 0);
    end

    // Back-pressure: first result held for 5 cycles.
    write_w(0, 1, 2, 3);
    load_t1();
    model(0, 5);
    run_frame(0, 5, 1'b0, 5, 1'b0, 1'b0);

    // Reset in the middle of a frame, with the first result already on the output.
    start = 1'b1; start_bank = 2'd0; frame_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(xbuf[i]);
      @(posedge clk); #1;
    end
    check("pre_rst_m_valid", int'(sif0.m_valid), 1);
    rst = 1'b1; s_valid = 1'b0;
    #1;
    check("midrst_m_valid", int'(sif0.m_valid), 0);
    check("midrst_m_data", int'(sif0.m_data), 0);
    check("midrst_s_ready", int'(sif0.s_ready), 0);
    check("midrst_busy", int'(busy0), 0);
    check("midrst_done", int'(done0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 3; k++) wm[i][k] = 0;
    nmv = 0; ndn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (sif0.m_valid) nmv++;
      if (done0) ndn++;
    end
    check("post_rst_m_valid_count", nmv, 0);
    check("post_rst_done_count", ndn, 0);

    // Weights were cleared by reset; then reload and repeat the frame.
    model(0, 5);
    run_frame(0, 5, 1'b0, 0, 1'b0, 1'b0);
    write_w(0, 1, 2, 3);
    model(0, 5);
    run_frame(0, 5, 1'b0, 0, 1'b0, 1'b1);

    for (int f = 0; f < 8; f++) begin
      b = int'($urandom_range(0, 3));
      len = int'($urandom_range(3, 14));
      write_w(b, rnd8(), rnd8(), rnd8());
      for (int k = 0; k < len; k++) xbuf[k] = rnd8();
      model(b, len);
      run_frame(b, len, 1'b1, 0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
